// File: rtl/tug_of_war_ctrl_if.sv
// Tug-of-war controller bus.
// Groups the player/start inputs and the game-state outputs of tug_of_war_ctrl.
//   start, pa, pb        : single-cycle pulses into the controller
//   leds, pos, state     : marker display, marker index, FSM state code
//   a_rnd_win, b_rnd_win : one-cycle round-win pulses
//   a_score, b_score     : rounds won per player
//   match_done           : high while the match is over
//   match_winner         : 0 = A, 1 = B (valid while match_done=1)
// master: the side producing pulses (player logic / testbench)
// slave : the controller itself
interface tug_of_war_ctrl_if #(
  parameter int N          = 4,
  parameter int WIN_ROUNDS = 2
);
  localparam int LED_W   = 2 * N + 1;
  localparam int POS_W   = $clog2(2 * N + 1);
  localparam int SCORE_W = $clog2(WIN_ROUNDS + 1);

  logic               start;
  logic               pa;
  logic               pb;
  logic [LED_W-1:0]   leds;
  logic [POS_W-1:0]   pos;
  logic [1:0]         state;
  logic               a_rnd_win;
  logic               b_rnd_win;
  logic [SCORE_W-1:0] a_score;
  logic [SCORE_W-1:0] b_score;
  logic               match_done;
  logic               match_winner;

  modport master (
    output start, pa, pb,
    input  leds, pos, state, a_rnd_win, b_rnd_win,
           a_score, b_score, match_done, match_winner
  );

  modport slave (
    input  start, pa, pb,
    output leds, pos, state, a_rnd_win, b_rnd_win,
           a_score, b_score, match_done, match_winner
  );
endinterface

// File: rtl/tug_of_war_ctrl.sv
// Tug-of-war game controller.
// Consumes one-cycle push pulses from two players, moves a marker across a
// 2N+1 LED bar, scores rounds and declares a match winner.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : tug_of_war_ctrl_if slave (start/pa/pb in, game state out)
// Every output is a register; leds is kept as the one-hot decode of pos by
// updating both at the same edge from the same value.
module tug_of_war_ctrl #(
  parameter int N           = 4,
  parameter int WIN_ROUNDS  = 2,
  parameter int HOLD_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  tug_of_war_ctrl_if.slave bus
);
  localparam int LED_W   = 2 * N + 1;
  localparam int POS_W   = $clog2(2 * N + 1);
  localparam int SCORE_W = $clog2(WIN_ROUNDS + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);

  localparam logic [POS_W-1:0]   POS_CENTRE = POS_W'(N);
  localparam logic [POS_W-1:0]   POS_A_END  = '0;
  localparam logic [POS_W-1:0]   POS_B_END  = POS_W'(2 * N);
  localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_ROUNDS);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_PLAY      = 2'b01,
    S_ROUND_END = 2'b10,
    S_MATCH_END = 2'b11
  } state_t;

  state_t             st_q;
  logic [POS_W-1:0]   pos_q;
  logic [LED_W-1:0]   leds_q;
  logic [SCORE_W-1:0] a_score_q;
  logic [SCORE_W-1:0] b_score_q;
  logic               a_win_q;
  logic               b_win_q;
  logic               done_q;
  logic               winner_q;
  logic               last_b_q;   // winner of the round being held: 0 = A, 1 = B
  logic [HOLD_W-1:0]  hold_q;

  logic [POS_W-1:0]   step_pos;
  logic               a_hit;
  logic               b_hit;
  logic [SCORE_W-1:0] round_score;

  function automatic logic [LED_W-1:0] onehot(input logic [POS_W-1:0] p);
    onehot = LED_W'(1) << p;
  endfunction

  // Candidate marker position for this cycle's presses; simultaneous
  // presses cancel. Only meaningful in PLAY, where pos is never at an end.
  always_comb begin
    step_pos = pos_q;
    if (bus.pa && !bus.pb)
      step_pos = pos_q - POS_W'(1);
    else if (bus.pb && !bus.pa)
      step_pos = pos_q + POS_W'(1);
    a_hit = (step_pos == POS_A_END);
    b_hit = (step_pos == POS_B_END);
  end

  assign round_score = last_b_q ? b_score_q : a_score_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= S_IDLE;
      pos_q     <= POS_CENTRE;
      leds_q    <= onehot(POS_CENTRE);
      a_score_q <= '0;
      b_score_q <= '0;
      a_win_q   <= 1'b0;
      b_win_q   <= 1'b0;
      done_q    <= 1'b0;
      winner_q  <= 1'b0;
      last_b_q  <= 1'b0;
      hold_q    <= '0;
    end else begin
      a_win_q <= 1'b0;
      b_win_q <= 1'b0;
      unique case (st_q)
        S_IDLE: begin
          if (bus.start)
            st_q <= S_PLAY;
        end

        S_PLAY: begin
          if (a_hit) begin
            pos_q     <= POS_A_END;
            leds_q    <= onehot(POS_A_END);
            a_score_q <= a_score_q + SCORE_W'(1);
            a_win_q   <= 1'b1;
            last_b_q  <= 1'b0;
            hold_q    <= '0;
            st_q      <= S_ROUND_END;
          end else if (b_hit) begin
            pos_q     <= POS_B_END;
            leds_q    <= onehot(POS_B_END);
            b_score_q <= b_score_q + SCORE_W'(1);
            b_win_q   <= 1'b1;
            last_b_q  <= 1'b1;
            hold_q    <= '0;
            st_q      <= S_ROUND_END;
          end else begin
            pos_q  <= step_pos;
            leds_q <= onehot(step_pos);
          end
        end

        // hold_q counts completed ROUND_END cycles; the exit edge is the
        // one that ends the HOLD_CYCLES-th cycle.
        S_ROUND_END: begin
          hold_q <= hold_q + HOLD_W'(1);
          if (hold_q == HOLD_LAST) begin
            if (round_score == SCORE_WIN) begin
              st_q     <= S_MATCH_END;
              done_q   <= 1'b1;
              winner_q <= last_b_q;
            end else begin
              pos_q  <= POS_CENTRE;
              leds_q <= onehot(POS_CENTRE);
              st_q   <= S_PLAY;
            end
          end
        end

        S_MATCH_END: begin
          if (bus.start) begin
            a_score_q <= '0;
            b_score_q <= '0;
            pos_q     <= POS_CENTRE;
            leds_q    <= onehot(POS_CENTRE);
            done_q    <= 1'b0;
            st_q      <= S_PLAY;
          end
        end

        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign bus.leds         = leds_q;
  assign bus.pos          = pos_q;
  assign bus.state        = st_q;
  assign bus.a_rnd_win    = a_win_q;
  assign bus.b_rnd_win    = b_win_q;
  assign bus.a_score      = a_score_q;
  assign bus.b_score      = b_score_q;
  assign bus.match_done   = done_q;
  assign bus.match_winner = winner_q;
endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// Bench for tug_of_war_ctrl (N=4, WIN_ROUNDS=2, HOLD_CYCLES=8).
// Each step drives inputs, advances a behavioural game model and queues the
// expected post-edge outputs; after the edge the entry is popped and compared.
module tb_tug_of_war_ctrl;
  localparam int N    = 4;
  localparam int WIN  = 2;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tug_of_war_ctrl_if #(.N(N), .WIN_ROUNDS(WIN)) bus ();

  tug_of_war_ctrl #(.N(N), .WIN_ROUNDS(WIN), .HOLD_CYCLES(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int st;
    int pos;
    int a_sc;
    int b_sc;
    int aw;
    int bw;
    int md;
    int mw;
  } exp_t;

  exp_t sb[$];
  int tests  = 0;
  int failed = 0;

  // Behavioural game model
  int m_st = 0, m_pos = N, m_as = 0, m_bs = 0, m_aw = 0, m_bw = 0;
  int m_md = 0, m_mw = 0, m_hold = 0, m_last = 0;

  task automatic model(input logic s, input logic a, input logic b, input logic r);
    int np;
    exp_t e;
    if (r) begin
      m_st = 0; m_pos = N; m_as = 0; m_bs = 0; m_aw = 0; m_bw = 0;
      m_md = 0; m_mw = 0; m_hold = 0; m_last = 0;
    end else begin
      m_aw = 0;
      m_bw = 0;
      case (m_st)
        0: if (s) m_st = 1;
        1: begin
          np = m_pos;
          if (a && !b) np = np - 1;
          if (b && !a) np = np + 1;
          if (np == 0) begin
            m_pos = 0; m_as = m_as + 1; m_aw = 1; m_last = 0; m_hold = 0; m_st = 2;
          end else if (np == 2 * N) begin
            m_pos = 2 * N; m_bs = m_bs + 1; m_bw = 1; m_last = 1; m_hold = 0; m_st = 2;
          end else begin
            m_pos = np;
          end
        end
        2: begin
          m_hold = m_hold + 1;
          if (m_hold == HOLD) begin
            if ((m_last == 1 ? m_bs : m_as) == WIN) begin
              m_st = 3; m_md = 1; m_mw = m_last;
            end else begin
              m_pos = N; m_st = 1;
            end
          end
        end
        default: if (s) begin
          m_as = 0; m_bs = 0; m_pos = N; m_md = 0; m_st = 1;
        end
      endcase
    end
    e.st = m_st; e.pos = m_pos; e.a_sc = m_as; e.b_sc = m_bs;
    e.aw = m_aw; e.bw = m_bw; e.md = m_md; e.mw = m_mw;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    logic [8:0] exp_leds;
    tests++;
    assert (sb.size() != 0) else begin
      failed++;
      $error("FAIL scoreboard_empty: observed %0d expected >0", sb.size());
      return;
    end
    tests--;
    e = sb.pop_front();
    exp_leds = 9'd1 << e.pos;
    chk("state", 32'(bus.state), 32'(e.st));
    chk("pos", 32'(bus.pos), 32'(e.pos));
    chk("leds", 32'(bus.leds), 32'(exp_leds));
    chk("a_score", 32'(bus.a_score), 32'(e.a_sc));
    chk("b_score", 32'(bus.b_score), 32'(e.b_sc));
    chk("a_rnd_win", 32'(bus.a_rnd_win), 32'(e.aw));
    chk("b_rnd_win", 32'(bus.b_rnd_win), 32'(e.bw));
    chk("match_done", 32'(bus.match_done), 32'(e.md));
    if (e.md == 1)
      chk("match_winner", 32'(bus.match_winner), 32'(e.mw));
  endtask

  // Inputs change 1 time unit after the active edge, outputs are sampled there too.
  task automatic step(input logic s, input logic a, input logic b, input logic r = 1'b0);
    bus.start = s;
    bus.pa    = a;
    bus.pb    = b;
    rst       = r;
    model(s, a, b, r);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.pa    = 1'b0;
    bus.pb    = 1'b0;
    #2;

    // Reset, with pushes present that must be ignored
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("reset_pos", 32'(bus.pos), 32'd4);
    chk("reset_leds", 32'(bus.leds), 32'h010);
    chk("reset_state", 32'(bus.state), 32'd0);

    // Pushes in IDLE do nothing
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("idle_pos", 32'(bus.pos), 32'd4);

    // Start, then A wins round 1
    step(1'b1, 1'b0, 1'b0);
    chk("start_state", 32'(bus.state), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    chk("r1_pos", 32'(bus.pos), 32'd0);
    chk("r1_a_win", 32'(bus.a_rnd_win), 32'd1);
    chk("r1_a_score", 32'(bus.a_score), 32'd1);
    chk("r1_state", 32'(bus.state), 32'd2);
    idle(1);
    chk("r1_win_pulse_end", 32'(bus.a_rnd_win), 32'd0);
    idle(6);
    chk("r1_hold7_state", 32'(bus.state), 32'd2);
    chk("r1_hold7_pos", 32'(bus.pos), 32'd0);
    idle(1);
    chk("r1_hold_exit_state", 32'(bus.state), 32'd1);
    chk("r1_hold_exit_pos", 32'(bus.pos), 32'd4);

    // Simultaneous presses cancel, then a single pb; start ignored in PLAY
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    chk("cancel_pos", 32'(bus.pos), 32'd4);
    step(1'b0, 1'b0, 1'b1);
    chk("pb_pos", 32'(bus.pos), 32'd5);
    step(1'b1, 1'b0, 1'b0);
    chk("start_in_play_state", 32'(bus.state), 32'd1);
    step(1'b0, 1'b1, 1'b0);

    // B round 1, pushes and start during hold ignored
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    chk("b1_pos", 32'(bus.pos), 32'd8);
    chk("b1_b_win", 32'(bus.b_rnd_win), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    idle(3);
    chk("b1_hold7_state", 32'(bus.state), 32'd2);
    idle(1);
    chk("b1_hold_exit_pos", 32'(bus.pos), 32'd4);

    // B round 2 wins the match
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    idle(HOLD);
    chk("match_state", 32'(bus.state), 32'd3);
    chk("match_done", 32'(bus.match_done), 32'd1);
    chk("match_winner_b", 32'(bus.match_winner), 32'd1);
    chk("match_b_score", 32'(bus.b_score), 32'd2);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("match_frozen_pos", 32'(bus.pos), 32'd8);

    // Restart from MATCH_END
    step(1'b1, 1'b0, 1'b0);
    chk("restart_state", 32'(bus.state), 32'd1);
    chk("restart_a_score", 32'(bus.a_score), 32'd0);
    chk("restart_b_score", 32'(bus.b_score), 32'd0);
    chk("restart_done", 32'(bus.match_done), 32'd0);

    // A wins a round, then reset mid-play at pos 2
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    idle(HOLD);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("pre_reset_pos", 32'(bus.pos), 32'd2);
    chk("pre_reset_a_score", 32'(bus.a_score), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("mid_reset_state", 32'(bus.state), 32'd0);
    chk("mid_reset_leds", 32'(bus.leds), 32'h010);
    chk("mid_reset_a_score", 32'(bus.a_score), 32'd0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/tug_of_war_ctrl.md
Name: tug_of_war_ctrl

Overview:
Game controller for the tug-of-war design. Consumes the single-cycle push pulses produced by the per-player one-pulse stages. Arbitrates between the two players and moves a rope marker across an LED bar. Scores rounds and declares a match winner.

Parameters:
N, 4, marker travel per side; LED bar is 2N+1 wide, centre index N, A wins at index 0, B wins at index 2N
WIN_ROUNDS, 2, rounds needed to win the match
HOLD_CYCLES, 8, cycles the final marker position is held after a round is won (≥1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  single-cycle start/restart pulse
pa  input  1  player A push pulse, one cycle wide
pb  input  1  player B push pulse, one cycle wide
leds  output  2N+1  one-hot marker position
pos  output  clog2(2N+1)  marker index
state  output  2  00 IDLE, 01 PLAY, 10 ROUND_END, 11 MATCH_END
a_rnd_win  output  1  one-cycle pulse: A won a round
b_rnd_win  output  1  one-cycle pulse: B won a round
a_score  output  clog2(WIN_ROUNDS+1)  rounds won by A
b_score  output  clog2(WIN_ROUNDS+1)  rounds won by B
match_done  output  1  high while in MATCH_END
match_winner  output  1  0 = A, 1 = B; valid only while match_done=1

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: state=IDLE, pos=N, leds=bit N only, scores=0, a_rnd_win=0, b_rnd_win=0, match_done=0, match_winner=0, hold counter=0.
- Reset mid-game returns to these values on the next edge. Inputs are ignored while rst=1.
- leds is always the one-hot decode of pos.

IDLE:
- pos held at N.
- pa and pb are ignored.
- start=1 → PLAY at the next edge.

PLAY: evaluated per cycle.
- pa=1, pb=0 → pos-1.
- pb=1, pa=0 → pos+1.
- pa=1, pb=1 → presses cancel; pos unchanged.
- start is ignored.
- A round is won when the next pos equals 0 (A) or 2N (B). On that edge:
  - pos takes the end value.
  - The winner's score increments.
  - The matching a_rnd_win or b_rnd_win is high for exactly the following cycle.
  - state → ROUND_END.
  - Hold counter is cleared.
- Latency: a press at edge k is visible on pos/leds after edge k (one cycle).

ROUND_END:
- pa, pb and start are ignored.
- pos is frozen at the end value.
- The hold counter increments each cycle.
- After exactly HOLD_CYCLES cycles in ROUND_END:
  - If the winner's score equals WIN_ROUNDS: state → MATCH_END, match_done=1, match_winner set.
  - Otherwise: pos → N, state → PLAY.

MATCH_END:
- match_done=1. Scores and pos are frozen. pa and pb are ignored.
- start=1 → scores cleared to 0, pos=N, match_done=0, state → PLAY, all at the same edge.

Scores:
- Never exceed WIN_ROUNDS.
- No wrap-around possible because the match ends at WIN_ROUNDS.

Pulse rule:
- pa/pb held high for several cycles (non-pulse input) move the marker one step per cycle. This is legal, and the one-pulse stages are relied upon upstream.

Test Plan:
1. Reset, start, then 4 pa pulses (N=4) → pos 4→3→2→1→0; a_rnd_win high for 1 cycle; a_score=1; state=ROUND_END; pos held for 8 cycles, then pos=4, state=PLAY.
2. In PLAY, pa and pb asserted in the same cycle ×3, then a single pb → pos stays 4 through the simultaneous presses, then 5; no win pulses.
3. Full match with WIN_ROUNDS=2: B wins two rounds (4 pb pulses each) → b_score=2, state=MATCH_END after hold, match_done=1, match_winner=1; further pa/pb leave all outputs unchanged.
4. From MATCH_END, pulse start → next cycle a_score=b_score=0, pos=4, match_done=0, state=PLAY. start pulsed during PLAY or ROUND_END → no effect.
5. pa/pb pulsed in IDLE and during ROUND_END hold → pos and scores unchanged; the hold still lasts exactly 8 cycles.
6. Assert rst mid-PLAY at pos=2 with a_score=1 → after the edge all outputs return to reset values; state=IDLE; leds=bit 4.
